// File: rtl/bwt_pkg.sv
// Shared definitions for the BWT match scheduler.
// Contents:
//   - default width constants for reference/SA addresses, target-SRAM base and read ID
//   - sched_state_e : scheduler FSM state encoding
//   - req_t         : request record {id, base} at the default widths
package bwt_pkg;

  localparam int REF_LENGTH  = 10;
  localparam int TAGT_LENGTH = 5;
  localparam int ID_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_EMIT   = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [ID_W-1:0]        id;
    logic [TAGT_LENGTH-1:0] base;
  } req_t;

endpackage

// File: rtl/bwt_req_fifo.sv
// Synchronous request FIFO holding {read id, target base} records.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   push, wdata     : write request (ignored while full)
//   pop, rdata      : read request (ignored while empty); rdata shows the head entry
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
module bwt_req_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // The count register, not the pointers, tells full from empty.
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/bwt_match_sched.sv
// Request scheduler/sequencer for the single BWT match engine.
// Jobs {read id, target base} are queued in a small FIFO, launched one at a
// time, supervised by a watchdog, and the resulting SA interval is returned
// tagged with the read id over a valid/ready port.
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   req_valid/req_ready/req_id/req_base : job input (req_ready = FIFO not full)
//   eng_start, eng_base, eng_abort   : engine control (registered)
//   eng_done, eng_hit, eng_loc1/2    : engine status (sampled only in WAIT)
//   res_valid/res_ready, res_*       : result output (registered, held until accepted)
//   busy                             : FSM active or jobs queued
module bwt_match_sched #(
  parameter int REF_LENGTH  = bwt_pkg::REF_LENGTH,
  parameter int TAGT_LENGTH = bwt_pkg::TAGT_LENGTH,
  parameter int ID_W        = bwt_pkg::ID_W,
  parameter int QDEPTH      = 4,
  parameter int TIMEOUT     = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ID_W-1:0]        req_id,
  input  logic [TAGT_LENGTH-1:0] req_base,
  output logic                   eng_start,
  output logic [TAGT_LENGTH-1:0] eng_base,
  output logic                   eng_abort,
  input  logic                   eng_done,
  input  logic                   eng_hit,
  input  logic [REF_LENGTH-1:0]  eng_loc1,
  input  logic [REF_LENGTH-1:0]  eng_loc2,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [REF_LENGTH-1:0]  res_loc1,
  output logic [REF_LENGTH-1:0]  res_loc2,
  output logic                   res_hit,
  output logic                   res_timeout,
  output logic                   busy
);

  import bwt_pkg::*;

  localparam int FW = ID_W + TAGT_LENGTH;
  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(QDEPTH) + 1;

  sched_state_e            state_q, state_d;
  logic [ID_W-1:0]         job_id_q, job_id_d;
  logic [TAGT_LENGTH-1:0]  job_base_q, job_base_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    eng_start_q, eng_start_d;
  logic                    eng_abort_q, eng_abort_d;
  logic                    res_valid_q, res_valid_d;
  logic [ID_W-1:0]         res_id_q, res_id_d;
  logic [REF_LENGTH-1:0]   res_loc1_q, res_loc1_d;
  logic [REF_LENGTH-1:0]   res_loc2_q, res_loc2_d;
  logic                    res_hit_q, res_hit_d;
  logic                    res_timeout_q, res_timeout_d;

  logic                    fifo_push, fifo_pop;
  logic                    fifo_full, fifo_empty;
  logic [FW-1:0]           fifo_rdata;
  logic [CW-1:0]           fifo_count;
  logic [ID_W-1:0]         head_id;
  logic [TAGT_LENGTH-1:0]  head_base;

  // Full means not ready, even if IDLE pops in the same cycle.
  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && !fifo_full;
  assign {head_id, head_base} = fifo_rdata;

  bwt_req_fifo #(
    .WIDTH (FW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({req_id, req_base}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    job_id_d      = job_id_q;
    job_base_d    = job_base_q;
    timer_d       = timer_q;
    eng_start_d   = 1'b0;
    eng_abort_d   = 1'b0;
    res_valid_d   = res_valid_q;
    res_id_d      = res_id_q;
    res_loc1_d    = res_loc1_q;
    res_loc2_d    = res_loc2_q;
    res_hit_d     = res_hit_q;
    res_timeout_d = res_timeout_q;
    fifo_pop      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          job_id_d    = head_id;
          job_base_d  = head_base;
          // Registered so the pulse lines up with the LAUNCH cycle.
          eng_start_d = 1'b1;
          state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (eng_done) begin
          res_valid_d   = 1'b1;
          res_id_d      = job_id_q;
          res_hit_d     = eng_hit;
          res_loc1_d    = eng_hit ? eng_loc1 : '0;
          res_loc2_d    = eng_hit ? eng_loc2 : '0;
          res_timeout_d = 1'b0;
          state_d       = ST_EMIT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          eng_abort_d   = 1'b1;
          res_valid_d   = 1'b1;
          res_id_d      = job_id_q;
          res_hit_d     = 1'b0;
          res_loc1_d    = '0;
          res_loc2_d    = '0;
          res_timeout_d = 1'b1;
          state_d       = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      job_id_q      <= '0;
      job_base_q    <= '0;
      timer_q       <= '0;
      eng_start_q   <= 1'b0;
      eng_abort_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_loc1_q    <= '0;
      res_loc2_q    <= '0;
      res_hit_q     <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      job_id_q      <= job_id_d;
      job_base_q    <= job_base_d;
      timer_q       <= timer_d;
      eng_start_q   <= eng_start_d;
      eng_abort_q   <= eng_abort_d;
      res_valid_q   <= res_valid_d;
      res_id_q      <= res_id_d;
      res_loc1_q    <= res_loc1_d;
      res_loc2_q    <= res_loc2_d;
      res_hit_q     <= res_hit_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  // job_base_q only changes on a pop, so it is stable from LAUNCH through WAIT.
  assign eng_base    = job_base_q;
  assign eng_start   = eng_start_q;
  assign eng_abort   = eng_abort_q;
  assign res_valid   = res_valid_q;
  assign res_id      = res_id_q;
  assign res_loc1    = res_loc1_q;
  assign res_loc2    = res_loc2_q;
  assign res_hit     = res_hit_q;
  assign res_timeout = res_timeout_q;
  assign busy        = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_bwt_match_sched.sv
module tb_bwt_match_sched;
  import bwt_pkg::*;

  localparam int RL = 10;
  localparam int TL = 5;
  localparam int IW = 4;
  localparam int QD = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [IW-1:0] req_id;
  logic [TL-1:0] req_base;
  logic          eng_start, eng_abort, eng_done, eng_hit;
  logic [TL-1:0] eng_base;
  logic [RL-1:0] eng_loc1, eng_loc2;
  logic          res_valid, res_ready, res_hit, res_timeout, busy;
  logic [IW-1:0] res_id;
  logic [RL-1:0] res_loc1, res_loc2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bwt_match_sched #(
    .REF_LENGTH (RL), .TAGT_LENGTH (TL), .ID_W (IW), .QDEPTH (QD), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready), .req_id (req_id), .req_base (req_base),
    .eng_start (eng_start), .eng_base (eng_base), .eng_abort (eng_abort),
    .eng_done (eng_done), .eng_hit (eng_hit), .eng_loc1 (eng_loc1), .eng_loc2 (eng_loc2),
    .res_valid (res_valid), .res_ready (res_ready), .res_id (res_id),
    .res_loc1 (res_loc1), .res_loc2 (res_loc2), .res_hit (res_hit),
    .res_timeout (res_timeout), .busy (busy)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [TL-1:0] base;
    int            dly;   // WAIT cycle (1-based) in which done is raised; 0 = never
    logic          hit;
    logic [RL-1:0] l1, l2;
    logic [RL-1:0] e_l1, e_l2;
    logic          e_hit, e_to;
  } vec_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [RL-1:0] l1, l2;
    logic          hit, to;
  } res_t;

  vec_t vecs[6];
  req_t pending[$];
  res_t expq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    check({tag, "_eng_abort"}, 32'(eng_abort), 32'd0);
    check({tag, "_eng_base"},  32'(eng_base),  32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_id"},    32'(res_id),    32'd0);
    check({tag, "_res_loc1"},  32'(res_loc1),  32'd0);
    check({tag, "_res_loc2"},  32'(res_loc2),  32'd0);
    check({tag, "_res_hit"},   32'(res_hit),   32'd0);
    check({tag, "_res_to"},    32'(res_timeout), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  task automatic push_job(input logic [IW-1:0] id, input logic [TL-1:0] base);
    check("push_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_id = id; req_base = base;
    tick();
    req_valid = 1'b0;
  endtask

  // Runs one job from its launch to the result handshake, driving the engine.
  task automatic serve(input vec_t v, input string tag);
    bit seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (eng_start) begin seen = 1; break; end
      tick();
    end
    check({tag, "_start_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, "_eng_base"}, 32'(eng_base), 32'(v.base));
    tick();
    check({tag, "_start_pulse"}, 32'(eng_start), 32'd0);
    for (int k = 1; k <= TO; k++) begin
      if (k == v.dly) begin
        eng_done = 1'b1; eng_hit = v.hit; eng_loc1 = v.l1; eng_loc2 = v.l2;
      end else begin
        eng_done = 1'b0; eng_hit = 1'b1; eng_loc1 = 10'h2C3; eng_loc2 = 10'h1B4;
      end
      tick();
      eng_done = 1'b0;
      if (k == v.dly || k == TO) break;
      check({tag, "_wait_valid"}, 32'(res_valid), 32'd0);
      check({tag, "_wait_base"},  32'(eng_base),  32'(v.base));
    end
    check({tag, "_res_valid"}, 32'(res_valid),   32'd1);
    check({tag, "_abort"},     32'(eng_abort),   32'(v.e_to));
    check({tag, "_res_id"},    32'(res_id),      32'(v.id));
    check({tag, "_res_loc1"},  32'(res_loc1),    32'(v.e_l1));
    check({tag, "_res_loc2"},  32'(res_loc2),    32'(v.e_l2));
    check({tag, "_res_hit"},   32'(res_hit),     32'(v.e_hit));
    check({tag, "_res_to"},    32'(res_timeout), 32'(v.e_to));
    // Stray done while the result waits must not disturb it.
    eng_done = 1'b1; eng_hit = ~v.e_hit; eng_loc1 = 10'h155; eng_loc2 = 10'h0AA;
    tick();
    eng_done = 1'b0;
    check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_abort_once"}, 32'(eng_abort), 32'd0);
    check({tag, "_hold_loc1"},  32'(res_loc1),  32'(v.e_l1));
    check({tag, "_hold_hit"},   32'(res_hit),   32'(v.e_hit));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t v;
    bit   ok;
    req_t cur;
    int   k, dly, due_to;
    bit   active, due, drained;
    logic hit;
    logic [RL-1:0] l1, l2;

    vecs[0] = '{4'd3,  5'd31, 5, 1'b1, 10'h12A, 10'h12F, 10'h12A, 10'h12F, 1'b1, 1'b0};
    vecs[1] = '{4'd5,  5'd10, 2, 1'b0, 10'h3FF, 10'h3FF, 10'h000, 10'h000, 1'b0, 1'b0};
    vecs[2] = '{4'd9,  5'd7,  0, 1'b1, 10'h111, 10'h222, 10'h000, 10'h000, 1'b0, 1'b1};
    vecs[3] = '{4'd0,  5'd16, 7, 1'b0, 10'h123, 10'h321, 10'h000, 10'h000, 1'b0, 1'b0};
    vecs[4] = '{4'd12, 5'd20, TO, 1'b1, 10'h055, 10'h2AA, 10'h055, 10'h2AA, 1'b1, 1'b0};
    vecs[5] = '{4'd15, 5'd1,  1, 1'b1, 10'h000, 10'h3FF, 10'h000, 10'h3FF, 1'b1, 1'b0};

    rst = 1'b0; req_valid = 1'b0; req_id = '0; req_base = '0;
    eng_done = 1'b0; eng_hit = 1'b0; eng_loc1 = '0; eng_loc2 = '0; res_ready = 1'b0;
    tick(); tick();
    check_reset_outputs("init");
    #3 rst = 1'b1;
    tick();

    // Table vectors: each job pushed into an empty idle block.
    for (int i = 0; i < 6; i++) begin
      push_job(vecs[i].id, vecs[i].base);
      check("lat_pop_cycle", 32'(eng_start), 32'd0);
      check("lat_busy", 32'(busy), 32'd1);
      tick();
      check("lat_launch", 32'(eng_start), 32'd1);
      serve(vecs[i], $sformatf("vec%0d", i));
    end

    // Done pulses with nothing in flight are ignored.
    eng_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_done_start", 32'(eng_start), 32'd0);
      check("idle_done_valid", 32'(res_valid), 32'd0);
      check("idle_done_busy",  32'(busy),      32'd0);
    end
    eng_done = 1'b0;

    // FIFO full with a stalled result consumer.
    res_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_id = IW'(i); req_base = TL'(i + 8);
      check($sformatf("full_ready%0d", i), 32'(req_ready), 32'd1);
      tick();
    end
    req_valid = 1'b0;
    check("full_ready_low", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_id = 4'd7; req_base = 5'd2;
    tick();
    req_valid = 1'b0;
    check("full_refused", 32'(req_ready), 32'd0);
    ok = 0;
    for (int n = 0; n < 30; n++) begin
      if (res_valid) begin ok = 1; break; end
      tick();
    end
    check("full_job0_valid", 32'(ok), 32'd1);
    for (int n = 0; n < 4; n++) begin
      check("stall_valid",   32'(res_valid),   32'd1);
      check("stall_id",      32'(res_id),      32'd0);
      check("stall_to",      32'(res_timeout), 32'd1);
      check("stall_loc1",    32'(res_loc1),    32'd0);
      check("stall_ready",   32'(req_ready),   32'd0);
      check("stall_nostart", 32'(eng_start),   32'd0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    for (int i = 1; i < 5; i++) begin
      v = '{IW'(i), TL'(i + 8), i + 1, 1'b1, RL'(i * 16 + 1), RL'(i * 16 + 2),
            RL'(i * 16 + 1), RL'(i * 16 + 2), 1'b1, 1'b0};
      serve(v, $sformatf("drain%0d", i));
    end
    check("drain_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of WAIT with jobs still queued.
    push_job(4'd10, 5'd3);
    push_job(4'd11, 5'd4);
    ok = 0;
    for (int n = 0; n < 10; n++) begin
      if (eng_start) begin ok = 1; break; end
      tick();
    end
    check("rst_launch", 32'(ok), 32'd1);
    tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    #2 rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("post_rst_start", 32'(eng_start), 32'd0);
      check("post_rst_busy",  32'(busy),      32'd0);
    end
    push_job(vecs[0].id, vecs[0].base);
    tick();
    serve(vecs[0], "post_rst");

    // Randomised traffic against a queue-based reference.
    active = 0; due = 0; due_to = 0; k = 0; dly = 0; drained = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc >= 2500 && pending.size() == 0 && expq.size() == 0 && !active && !due
          && !res_valid && !eng_start) begin
        drained = 1;
        break;
      end
      eng_done = 1'b0;
      eng_hit  = 1'($urandom);
      eng_loc1 = RL'($urandom);
      eng_loc2 = RL'($urandom);
      if (due) begin
        check("rnd_valid_rise", 32'(res_valid), 32'd1);
        check("rnd_abort", 32'(eng_abort), 32'(due_to));
        due = 0;
      end else begin
        check("rnd_no_abort", 32'(eng_abort), 32'd0);
      end
      if (active) begin
        k++;
        check("rnd_base_stable", 32'(eng_base), 32'(cur.base));
        if (k == dly) begin
          hit = 1'($urandom); l1 = RL'($urandom); l2 = RL'($urandom);
          eng_done = 1'b1; eng_hit = hit; eng_loc1 = l1; eng_loc2 = l2;
          expq.push_back('{cur.id, hit ? l1 : RL'(0), hit ? l2 : RL'(0), hit, 1'b0});
          active = 0; due = 1; due_to = 0;
        end else if (k == TO) begin
          expq.push_back('{cur.id, RL'(0), RL'(0), 1'b0, 1'b1});
          active = 0; due = 1; due_to = 1;
        end
      end else begin
        if (eng_start) begin
          if (pending.size() == 0) begin
            check("rnd_start_without_job", 32'd1, 32'(pending.size()));
          end else begin
            cur = pending.pop_front();
            check("rnd_launch_base", 32'(eng_base), 32'(cur.base));
            active = 1; k = 0; dly = $urandom_range(1, TO + 3);
          end
        end
        eng_done = ($urandom_range(0, 3) == 0);
      end
      check("rnd_req_ready", 32'(req_ready), 32'(pending.size() < QD));
      res_ready = ($urandom_range(0, 2) != 0);
      if (res_valid) begin
        if (expq.size() == 0) begin
          check("rnd_unexpected_result", 32'(res_valid), 32'd0);
        end else begin
          check("rnd_res_id",   32'(res_id),      32'(expq[0].id));
          check("rnd_res_loc1", 32'(res_loc1),    32'(expq[0].l1));
          check("rnd_res_loc2", 32'(res_loc2),    32'(expq[0].l2));
          check("rnd_res_hit",  32'(res_hit),     32'(expq[0].hit));
          check("rnd_res_to",   32'(res_timeout), 32'(expq[0].to));
          if (res_ready) void'(expq.pop_front());
        end
      end
      if (cyc < 2500 && $urandom_range(0, 1) == 1) begin
        req_valid = 1'b1; req_id = IW'($urandom); req_base = TL'($urandom);
        if (req_ready) pending.push_back('{req_id, req_base});
      end else begin
        req_valid = 1'b0;
      end
      tick();
    end
    req_valid = 1'b0; res_ready = 1'b0; eng_done = 1'b0;
    check("rnd_drained", 32'(drained), 32'd1);
    tick();
    check("rnd_final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
